clk_meter: RTL and testbench

CLK_METER -- requirements
Module: clk_meter

---
 rtl/clk_meter_pkg.sv | 14 +
 rtl/clk_meter_sync_2ff.sv | 20 ++
 rtl/clk_meter.sv | 172 +++++++++++++++++
 tb/tb_clk_meter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared definitions for clk_meter: FSM state encodings and averaging constants.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam int AVG_CNT   = 4;
    localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/clk_meter_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_meter.sv
// Measures period and high time of a slow clk_in in clk cycles.
// Define CLK_METER_AVG_EN to average the results over AVG_CNT consecutive periods.
//
// state | meaning
// IDLE  | waiting for start; results held
// ARM   | waiting for the first synchronized rising edge
// HIGH  | counting while clk_in is high
// LOW   | counting while clk_in is low, until the rising edge that closes the period
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time
);
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             clk_in_s;
    logic             clk_in_d;
    logic             rise;
    logic             fall;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] tmr;
    logic             tmr_tc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (clk_in),
        .q   (clk_in_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clk_in_d <= 1'b0;
        else     clk_in_d <= clk_in_s;
    end

    assign rise    = clk_in_s & ~clk_in_d;
    assign fall    = ~clk_in_s & clk_in_d;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;
    // Phase timer is a down-counter reloaded on every phase entry.
    assign tmr_tc  = (tmr <= ONE);

`ifdef CLK_METER_AVG_EN
    localparam int SUM_W = CNT_W + 2;
    logic [SUM_W-1:0] per_sum;
    logic [SUM_W-1:0] high_sum;
    logic [SUM_W-1:0] per_total;
    logic [1:0]       idx;

    assign per_total = per_sum + SUM_W'(cnt);
`else
    logic [CNT_W-1:0] high_cap;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            period    <= '0;
            high_time <= '0;
            cnt       <= '0;
            tmr       <= '0;
`ifdef CLK_METER_AVG_EN
            per_sum   <= '0;
            high_sum  <= '0;
            idx       <= '0;
`else
            high_cap  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high in the first IDLE cycle, which masks a coincident start
                    if (start && !done) begin
                        state   <= ARM;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        cnt     <= '0;
                        tmr     <= TMR_LOAD;
`ifdef CLK_METER_AVG_EN
                        per_sum  <= '0;
                        high_sum <= '0;
                        idx      <= '0;
`endif
                    end
                end
                ARM: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= ONE;
                        tmr   <= TMR_LOAD;
                    end else if (tmr_tc) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        tmr <= tmr - ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        cnt   <= cnt_inc;
                        tmr   <= TMR_LOAD;
`ifdef CLK_METER_AVG_EN
                        high_sum <= high_sum + SUM_W'(cnt);
`else
                        high_cap <= cnt;
`endif
                    end else if (tmr_tc) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                        tmr <= tmr - ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
`ifdef CLK_METER_AVG_EN
                        if (idx == 2'(AVG_CNT - 1)) begin
                            period    <= per_total[AVG_SHIFT +: CNT_W];
                            high_time <= high_sum[AVG_SHIFT +: CNT_W];
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            per_sum <= per_total;
                            idx     <= idx + 2'd1;
                            state   <= HIGH;
                            cnt     <= ONE;
                            tmr     <= TMR_LOAD;
                        end
`else
                        period    <= cnt;
                        high_time <= high_cap;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`endif
                    end else if (tmr_tc) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                        tmr <= tmr - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_meter.sv
// Directed self-checking bench for clk_meter (timeout shortened to 100 cycles).
module tb_clk_meter;
    localparam int CNT_W = 16;
    localparam int TMO   = 100;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             clk_in = 1'b0;
    logic             start  = 1'b0;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cyc_cnt    = 0;
    int   rise_cyc   = 0;
    int   rise_cnt   = 0;
    int   done_total = 0;
    int   gen_hi     = 3;
    int   gen_lo     = 2;
    int   ph         = 0;
    logic gen_en     = 1'b0;
    logic gen_level  = 1'b0;
    logic gen_nxt;

    clk_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (clk_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .period    (period),
        .high_time (high_time)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) if (done === 1'b1) done_total <= done_total + 1;

    // clk_in generator: changes 1 ns after a clk edge, either as a divider or a forced level
    always begin
        @(posedge clk);
        #1;
        if (gen_en) begin
            gen_nxt = (ph < gen_hi);
            ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
        end else begin
            gen_nxt = gen_level;
            ph = 0;
        end
        if (gen_nxt && !clk_in) begin
            rise_cyc = cyc_cnt;
            rise_cnt = rise_cnt + 1;
        end
        clk_in = gen_nxt;
    end

    task automatic set_div(input int hi, input int lo);
        gen_hi = hi;
        gen_lo = lo;
        ph     = 0;
        gen_en = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    task automatic set_level(input logic lvl);
        gen_en    = 1'b0;
        gen_level = lvl;
        repeat (6) @(posedge clk);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic measure(input int win, output int nd, output logic [CNT_W-1:0] per,
                           output logic [CNT_W-1:0] hi, output int lat);
        nd  = 0;
        per = '0;
        hi  = '0;
        lat = -1;
        repeat (win) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd  = nd + 1;
                per = period;
                hi  = high_time;
                lat = cyc_cnt - rise_cyc;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
        n_checks++; if (period !== 16'd0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
        n_checks++; if (high_time !== 16'd0) $display("FAIL reset_high_time: got %0d want 0", high_time); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_div5();
        int nd, lat;
        logic [CNT_W-1:0] per, hi;
        set_div(3, 2);
        pulse_start();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL div5_busy: got %b want 1", busy); else n_pass++;
        measure(60, nd, per, hi, lat);
        n_checks++; if (nd != 1) $display("FAIL div5_done_count: got %0d want 1", nd); else n_pass++;
        n_checks++; if (per !== 16'd5) $display("FAIL div5_period: got %0d want 5", per); else n_pass++;
        n_checks++; if (hi !== 16'd3) $display("FAIL div5_high_time: got %0d want 3", hi); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL div5_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL div5_timeout: got %b want 0", timeout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL div5_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_div4();
        int nd, lat;
        logic [CNT_W-1:0] per, hi;
        set_div(2, 2);
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            measure(60, nd, per, hi, lat);
            n_checks++; if (nd != 1) $display("FAIL div4_done_count[%0d]: got %0d want 1", r, nd); else n_pass++;
            n_checks++; if (per !== 16'd4) $display("FAIL div4_period[%0d]: got %0d want 4", r, per); else n_pass++;
            n_checks++; if (hi !== 16'd2) $display("FAIL div4_high_time[%0d]: got %0d want 2", r, hi); else n_pass++;
        end
    endtask

    task automatic test_timeout_arm();
        int d0;
        set_level(1'b0);
        d0 = done_total;
        pulse_start();
        repeat (100) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL tmo_arm_busy_before: got %b want 1", busy); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL tmo_arm_flag_before: got %b want 0", timeout); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL tmo_arm_busy_after: got %b want 0", busy); else n_pass++;
        n_checks++; if (timeout !== 1'b1) $display("FAIL tmo_arm_flag_after: got %b want 1", timeout); else n_pass++;
        repeat (5) @(negedge clk);
        @(posedge clk);
        n_checks++; if (done_total != d0) $display("FAIL tmo_arm_no_done: got %0d pulses want 0", done_total - d0); else n_pass++;
        n_checks++; if (period !== 16'd4) $display("FAIL tmo_arm_period_held: got %0d want 4", period); else n_pass++;
        n_checks++; if (high_time !== 16'd2) $display("FAIL tmo_arm_high_held: got %0d want 2", high_time); else n_pass++;
    endtask

    task automatic test_timeout_high();
        int d0;
        int elapsed;
        bit seen;
        d0 = done_total;
        pulse_start();
        @(negedge clk);
        n_checks++; if (timeout !== 1'b0) $display("FAIL tmo_high_cleared: got %b want 0", timeout); else n_pass++;
        gen_level = 1'b1;
        seen = 1'b0;
        elapsed = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                seen = 1'b1;
                elapsed = cyc_cnt - rise_cyc;
            end
        end
        n_checks++; if (elapsed != 103) $display("FAIL tmo_high_abort_cycle: got %0d want 103", elapsed); else n_pass++;
        n_checks++; if (timeout !== 1'b1) $display("FAIL tmo_high_flag: got %b want 1", timeout); else n_pass++;
        @(posedge clk);
        n_checks++; if (done_total != d0) $display("FAIL tmo_high_no_done: got %0d pulses want 0", done_total - d0); else n_pass++;
        n_checks++; if (period !== 16'd4) $display("FAIL tmo_high_period_held: got %0d want 4", period); else n_pass++;
        set_level(1'b0);
    endtask

    task automatic test_reset_mid();
        int nd, lat, r0;
        bit seen;
        logic [CNT_W-1:0] per, hi;
        set_div(3, 2);
        pulse_start();
        r0 = rise_cnt;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rise_cnt != r0) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL rst_mid_rise_seen: got 0 want 1"); else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_in_high: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy_cleared: got %b want 0", busy); else n_pass++;
        n_checks++; if (period !== 16'd0) $display("FAIL rst_mid_period_cleared: got %0d want 0", period); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        measure(40, nd, per, hi, lat);
        n_checks++; if (nd != 0) $display("FAIL rst_mid_no_done: got %0d want 0", nd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_idle_after: got %b want 0", busy); else n_pass++;
        pulse_start();
        measure(60, nd, per, hi, lat);
        n_checks++; if (nd != 1) $display("FAIL rst_mid_restart_done: got %0d want 1", nd); else n_pass++;
        n_checks++; if (per !== 16'd5) $display("FAIL rst_mid_restart_period: got %0d want 5", per); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nd, lat;
        logic [CNT_W-1:0] per, hi;
        pulse_start();
        pulse_start();
        measure(60, nd, per, hi, lat);
        n_checks++; if (nd != 1) $display("FAIL b2b_done_count: got %0d want 1", nd); else n_pass++;
        n_checks++; if (per !== 16'd5) $display("FAIL b2b_period: got %0d want 5", per); else n_pass++;
        n_checks++; if (hi !== 16'd3) $display("FAIL b2b_high_time: got %0d want 3", hi); else n_pass++;
    endtask

    task automatic test_start_on_done();
        int nd, lat;
        bit seen;
        logic [CNT_W-1:0] per, hi;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL sod_done_seen: got 0 want 1"); else n_pass++;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL sod_start_ignored: got busy %b want 0", busy); else n_pass++;
        measure(30, nd, per, hi, lat);
        n_checks++; if (nd != 0) $display("FAIL sod_no_extra_done: got %0d want 0", nd); else n_pass++;
        pulse_start();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL sod_next_start_taken: got busy %b want 1", busy); else n_pass++;
        measure(60, nd, per, hi, lat);
        n_checks++; if (nd != 1) $display("FAIL sod_next_done: got %0d want 1", nd); else n_pass++;
    endtask

`ifdef CLK_METER_AVG_EN
    task automatic test_avg();
        int d0;
        int lows [4] = '{2, 2, 2, 3};
        set_level(1'b0);
        d0 = done_total;
        pulse_start();
        for (int p = 0; p < 4; p++) begin
            gen_level = 1'b1;
            repeat (3) @(posedge clk);
            gen_level = 1'b0;
            repeat (lows[p]) @(posedge clk);
        end
        gen_level = 1'b1;
        repeat (3) @(posedge clk);
        gen_level = 1'b0;
        repeat (15) @(posedge clk);
        n_checks++; if (done_total - d0 != 1) $display("FAIL avg_done_count: got %0d want 1", done_total - d0); else n_pass++;
        n_checks++; if (period !== 16'd5) $display("FAIL avg_period: got %0d want 5", period); else n_pass++;
        n_checks++; if (high_time !== 16'd3) $display("FAIL avg_high_time: got %0d want 3", high_time); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_div5();
        test_div4();
        test_timeout_arm();
        test_timeout_high();
        test_reset_mid();
        test_back_to_back();
        test_start_on_done();
`ifdef CLK_METER_AVG_EN
        test_avg();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
